instr_fetch_unit: RTL and testbench

//   Fetch stage feeding the decode stage (IF/ID register) of the 16-bit-instruction pipeline.

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/ifu_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared instruction-format definitions for fetch, decode and execute.
// 16-bit words: opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0].
package ifu_pkg;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LOAD = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with clear; head is combinational from storage (first-word fall-through).
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, rptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, queues returned words for decode.
// Define IFU_HALT_DECODE_EN to stop fetching after a pushed HALT (opcode 4'hF) until the next flush.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int DEPTH   = 4,
  parameter int INSTR_W = ifu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               halted
);
  import ifu_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = PC_W + INSTR_W;

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   q_count, tag_count;
  logic [CW:0]     occupancy;
  logic            q_full, q_empty, tag_full, tag_empty;
  logic [QW-1:0]   q_rdata;
  logic [PC_W-1:0] tag_pc;
  logic            accept, rsp_keep, push, pop, halt_st;
  logic            unused_flags;

  assign halt_st   = (state_q == ST_HALT);
  assign occupancy = {1'b0, q_count} + {1'b0, inflight_q};

  // Reset gates the request combinationally so it falls as soon as reset asserts.
  assign imem_req  = reset && (occupancy < (CW+1)'(DEPTH)) && !flush && !halt_st;
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_gnt;

  assign rsp_keep  = imem_rvalid && (drop_q == '0);
  assign push      = rsp_keep && !halt_st && !flush;
  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc    = q_rdata[QW-1:INSTR_W];
  assign out_instr = q_rdata[INSTR_W-1:0];

  // Tags follow requests in order; dropped (stale) responses never consume one
  // because the flush that made them stale also cleared the tag FIFO.
  ifu_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (accept),
    .pop   (rsp_keep),
    .clear (flush),
    .wdata (pc_q),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  ifu_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({tag_pc, imem_rdata}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign unused_flags = ^{q_full, tag_full, tag_empty, tag_count};

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
    drop_d     = drop_q;
    if (flush) begin
      pc_d   = flush_pc;
      drop_d = inflight_q - CW'(imem_rvalid);
    end else begin
      if (accept) pc_d = pc_q + 1'b1;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
`ifdef IFU_HALT_DECODE_EN
        if (push && (opcode_of(imem_rdata) == OP_HALT)) state_d = ST_HALT;
`endif
      end
      ST_HALT: if (flush) state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      state_q    <= ST_RUN;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

`ifdef IFU_HALT_DECODE_EN
  assign halted = halt_st;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with programmable latency/grant, scoreboard of
// accepted fetches checked at every pop, a table of flush/latency scenarios, and corner sequences.
module tb_instr_fetch_unit;
  localparam int PC_W  = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 16;
`ifdef IFU_HALT_DECODE_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req, imem_gnt, imem_rvalid;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata;
  logic            out_valid, out_ready, flush, halted;
  logic [IW-1:0]   out_instr;
  logic [PC_W-1:0] out_pc, flush_pc;

  instr_fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .INSTR_W(IW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .flush_pc(flush_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   instr;
  } fetch_t;

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } pend_t;

  typedef struct packed {
    logic [7:0]        start;
    logic [3:0]        lat;
    logic              rnd;
    logic [0:3][7:0]   pc;
    logic [0:3][15:0]  ins;
  } row_t;

  logic [IW-1:0] mem [256];
  fetch_t        exp_q[$];
  fetch_t        obs_q[$];
  pend_t         pend_q[$];
  row_t          tbl[5];
  int            cyc, lat, nvec, nerr, nacc;
  bit            gnt_rand, gnt_val, mhalt;
  logic          s_rst, s_flush, s_ready;
  logic [7:0]    s_fpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_row(input int i, input logic [7:0] s, input logic [3:0] l, input logic r,
                         input logic [0:3][7:0] p, input logic [0:3][15:0] w);
    tbl[i].start = s; tbl[i].lat = l; tbl[i].rnd = r; tbl[i].pc = p; tbl[i].ins = w;
  endtask

  // One clock: drive everything at the falling edge, then sample the settled handshakes
  // that the coming rising edge will commit and update the memory model and scoreboard.
  task automatic tick();
    fetch_t got, want;
    @(negedge clk);
    cyc++;
    reset     = s_rst;
    flush     = s_flush;
    flush_pc  = s_fpc;
    out_ready = s_ready;
    imem_gnt  = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_val;
    if (!reset) begin
      pend_q.delete(); exp_q.delete(); mhalt = 1'b0; imem_rvalid = 1'b0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[pend_q[0].addr];
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
    #1;
    if (!reset) return;
    if (flush) begin
      exp_q.delete(); mhalt = 1'b0;
      return;
    end
    if (out_valid && out_ready) begin
      got = {out_pc, out_instr};
      obs_q.push_back(got);
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL sb_pop: got pc=%h instr=%h expected nothing (cycle %0d)", out_pc, out_instr, cyc);
      end else begin
        want = exp_q.pop_front();
        chk("sb_pop", 32'(got), 32'(want));
      end
    end
    if (imem_req && imem_gnt) begin
      nacc++;
      pend_q.push_back('{imem_addr, cyc + lat});
      if (!mhalt) begin
        exp_q.push_back({imem_addr, mem[imem_addr]});
        if (HALT_EN && mem[imem_addr][15:12] == 4'hF) mhalt = 1'b1;
      end
    end
  endtask

  task automatic do_flush(input logic [7:0] pc);
    s_flush = 1'b1; s_fpc = pc; tick(); s_flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
    mem[0] = 16'h1123; mem[1] = 16'h2410; mem[2] = 16'h3202; mem[3] = 16'h1541;
    mem[8'h20] = 16'h1123; mem[8'h21] = 16'hF000; mem[8'h22] = 16'h2410;

    set_row(0, 8'h00, 4'd1, 1'b0, {8'h00, 8'h01, 8'h02, 8'h03}, {16'h1123, 16'h2410, 16'h3202, 16'h1541});
    set_row(1, 8'hFE, 4'd1, 1'b0, {8'hFE, 8'hFF, 8'h00, 8'h01}, {16'h50FE, 16'h50FF, 16'h1123, 16'h2410});
    set_row(2, 8'h40, 4'd3, 1'b0, {8'h40, 8'h41, 8'h42, 8'h43}, {16'h5040, 16'h5041, 16'h5042, 16'h5043});
    set_row(3, 8'h80, 4'd2, 1'b1, {8'h80, 8'h81, 8'h82, 8'h83}, {16'h5080, 16'h5081, 16'h5082, 16'h5083});
    set_row(4, 8'h7E, 4'd4, 1'b1, {8'h7E, 8'h7F, 8'h80, 8'h81}, {16'h507E, 16'h507F, 16'h5080, 16'h5081});

    nvec = 0; nerr = 0; cyc = 0; nacc = 0; lat = 1; mhalt = 1'b0;
    gnt_rand = 1'b0; gnt_val = 1'b1;
    reset = 1'b0; s_rst = 1'b0; s_flush = 1'b0; s_fpc = '0; s_ready = 1'b1;
    flush = 1'b0; flush_pc = '0; out_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // reset state
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out", {out_pc, out_instr}, 0);

    // zero-wait memory: two-cycle fill then one word per cycle
    s_rst = 1'b1;
    tick();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 8'h00);
    chk("t1_valid0", out_valid, 0);
    tick();
    chk("t1_valid1", out_valid, 0);
    tick();
    chk("t1_w0", {out_valid, out_pc, out_instr}, {1'b1, 8'h00, 16'h1123});
    tick();
    chk("t1_w1", {out_valid, out_pc, out_instr}, {1'b1, 8'h01, 16'h2410});
    tick();
    chk("t1_w2", {out_valid, out_pc, out_instr}, {1'b1, 8'h02, 16'h3202});
    tick();
    chk("t1_w3", {out_valid, out_pc, out_instr}, {1'b1, 8'h03, 16'h1541});

    // scenario table: redirect, latency, grant pattern, first four delivered words
    for (int r = 0; r < 5; r++) begin
      lat = int'(tbl[r].lat); gnt_rand = tbl[r].rnd; gnt_val = 1'b1; s_ready = 1'b1;
      do_flush(tbl[r].start);
      obs_q.delete();
      for (int k = 0; k < 200 && obs_q.size() < 4; k++) tick();
      chk("tbl_count", obs_q.size() >= 4, 1);
      if (obs_q.size() >= 4)
        for (int k = 0; k < 4; k++) begin
          chk("tbl_pc", obs_q[k].pc, tbl[r].pc[k]);
          chk("tbl_instr", obs_q[k].instr, tbl[r].ins[k]);
        end
    end

    // backpressure: request cap holds exactly DEPTH words
    lat = 1; gnt_rand = 1'b0; gnt_val = 1'b1; s_ready = 1'b0;
    do_flush(8'h60);
    nacc = 0;
    repeat (10) tick();
    chk("bp_accepts", nacc, 4);
    chk("bp_req_low", imem_req, 0);
    chk("bp_head", {out_valid, out_pc}, {1'b1, 8'h60});
    s_ready = 1'b1; obs_q.delete();
    repeat (6) tick();
    chk("bp_drain_n", obs_q.size() >= 4, 1);
    if (obs_q.size() >= 4)
      for (int k = 0; k < 4; k++) chk("bp_order", obs_q[k].pc, 8'h60 + 8'(k));

    // flush with two requests in flight at latency 3
    lat = 3; s_ready = 1'b1; gnt_val = 1'b1;
    do_flush(8'h30);
    tick(); tick();
    gnt_val = 1'b0;
    s_flush = 1'b1; s_fpc = 8'h40; tick(); s_flush = 1'b0;
    chk("fl_req_in_flush", imem_req, 0);
    gnt_val = 1'b1;
    tick();
    chk("fl_valid_after", out_valid, 0);
    for (int k = 0; k < 30 && !out_valid; k++) tick();
    chk("fl_first_pc", {out_valid, out_pc}, {1'b1, 8'h40});
    repeat (4) tick();

    // asynchronous reset mid-stream
    lat = 2;
    repeat (6) tick();
    #2 reset = 1'b0; s_rst = 1'b0;
    #1;
    chk("ar_req", imem_req, 0);
    chk("ar_valid", out_valid, 0);
    tick(); tick();
    s_rst = 1'b1;
    tick();
    chk("ar_restart", {imem_req, imem_addr}, {1'b1, 8'h00});
    repeat (8) tick();

    // HALT word handling
    lat = 1; gnt_val = 1'b1; s_ready = 1'b1;
    do_flush(8'h20);
    obs_q.delete();
    repeat (12) tick();
    chk("hl_w0", obs_q.size() > 0 ? obs_q[0].instr : 16'hxxxx, 16'h1123);
    chk("hl_w1", obs_q.size() > 1 ? obs_q[1].instr : 16'hxxxx, 16'hF000);
`ifdef IFU_HALT_DECODE_EN
    chk("hl_count", obs_q.size(), 2);
    chk("hl_halted", halted, 1);
    chk("hl_req", imem_req, 0);
`else
    chk("hl_w2", obs_q.size() > 2 ? obs_q[2].instr : 16'hxxxx, 16'h2410);
    chk("hl_halted", halted, 0);
`endif
    do_flush(8'h10);
    tick();
    chk("hl_resume_halted", halted, 0);
    chk("hl_resume_req", {imem_req, imem_addr}, {1'b1, 8'h10});
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
